// File: rtl/cache_control.sv
// cache_control: sequencer for a 2-way set-associative, write-back,
// write-allocate cache. Hits finish in IDLE in the request cycle. A miss
// writes the dirty victim back if needed, then fills the LRU way. It then
// returns to IDLE, where the held request is re-evaluated and hits.
// Saturating hit/miss/write-back counters are kept for performance analysis.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 is_hit,
    input  logic                 hit_sel,
    input  logic                 valid,
    input  logic                 victim_valid,
    input  logic                 victim_dirty,
    input  logic                 lru,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 pmem_addr_sel,
    output logic                 w_data_en,
    output logic                 w_tag_en,
    output logic                 w_valid_en,
    output logic                 w_dirty_en,
    output logic                 w_lru_en,
    output logic                 din_valid,
    output logic                 din_dirty,
    output logic                 din_lru,
    input  logic                 clr_stats,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state;
    logic   hit;
    logic   req;
    logic   miss;
    logic   wb_done;
    logic   unused_lru;

    assign hit     = is_hit & valid;
    assign req     = mem_read | mem_write;
    assign miss    = (state == IDLE) & req & ~hit;
    assign wb_done = (state == WRITEBACK) & pmem_resp;

    // The datapath's fill-way mux uses lru directly.
    // The sequencer never needs the value itself.
    assign unused_lru = lru;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic                 en);
        return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    // Sequencing: leave WRITEBACK/FILL only on pmem_resp. Reset abandons a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      if (miss) state <= (victim_valid & victim_dirty) ? WRITEBACK : FILL;
                WRITEBACK: if (pmem_resp) state <= FILL;
                FILL:      if (pmem_resp) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Output decode: Mealy on hit in IDLE, and state-decoded elsewhere.
    // pmem_read/pmem_write depend only on state, never on pmem_resp.
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        w_data_en     = 1'b0;
        w_tag_en      = 1'b0;
        w_valid_en    = 1'b0;
        w_dirty_en    = 1'b0;
        w_lru_en      = 1'b0;
        din_valid     = 1'b0;
        din_dirty     = 1'b0;
        din_lru       = 1'b0;
        case (state)
            IDLE: begin
                // rst_n gating keeps every output quiet while reset is held
                if (rst_n && req && hit) begin
                    mem_resp = 1'b1;
                    w_lru_en = 1'b1;
                    din_lru  = ~hit_sel;
                    if (mem_write) begin
                        w_data_en  = 1'b1;
                        w_dirty_en = 1'b1;
                        din_dirty  = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    w_data_en  = 1'b1;
                    w_tag_en   = 1'b1;
                    w_valid_en = 1'b1;
                    w_dirty_en = 1'b1;
                    din_valid  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Statistics counters: they saturate at all-ones, and a clear beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (clr_stats) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            hit_count  <= sat_inc(hit_count, mem_resp);
            miss_count <= sat_inc(miss_count, miss);
            wb_count   <= sat_inc(wb_count, wb_done);
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: the bench emulates the cache arrays. The DUT's write
// enables drive that emulation, and it feeds is_hit/valid/victim/lru back.
// A separate transaction-level cache model tracks the expected array state,
// counters, pmem traffic and latency.
module tb_cache_control;

    localparam int CW   = 12;
    localparam int NS   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read = 1'b0, mem_write = 1'b0, mem_resp;
    logic          is_hit, hit_sel, valid, victim_valid, victim_dirty, lru;
    logic          pmem_resp = 1'b0, pmem_read, pmem_write, pmem_addr_sel;
    logic          w_data_en, w_tag_en, w_valid_en, w_dirty_en, w_lru_en;
    logic          din_valid, din_dirty, din_lru;
    logic          clr_stats = 1'b0;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .is_hit(is_hit), .hit_sel(hit_sel), .valid(valid),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .lru(lru),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .w_data_en(w_data_en), .w_tag_en(w_tag_en),
        .w_valid_en(w_valid_en), .w_dirty_en(w_dirty_en), .w_lru_en(w_lru_en),
        .din_valid(din_valid), .din_dirty(din_dirty), .din_lru(din_lru),
        .clr_stats(clr_stats), .hit_count(hit_count), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    // Emulated datapath arrays, written only through the DUT's enables
    int   e_tag [NS][2];
    bit   e_vld [NS][2];
    bit   e_dty [NS][2];
    bit   e_lru [NS];
    int   cur_s = 0;
    int   cur_t = 0;
    logic m0, m1, wr_way;

    // Datapath status lookup for the current address
    always_comb begin
        m0           = (e_tag[cur_s][0] == cur_t);
        m1           = (e_tag[cur_s][1] == cur_t);
        is_hit       = m0 | m1;
        hit_sel      = (m1 && e_vld[cur_s][1]) ? 1'b1 : ((m0 && e_vld[cur_s][0]) ? 1'b0 : m1);
        valid        = e_vld[cur_s][hit_sel];
        lru          = e_lru[cur_s];
        victim_valid = e_vld[cur_s][lru];
        victim_dirty = e_dty[cur_s][lru];
        wr_way       = pmem_read ? lru : hit_sel;
    end

    // Datapath array writes
    always @(posedge clk) begin
        if (w_tag_en)   e_tag[cur_s][wr_way] <= cur_t;
        if (w_valid_en) e_vld[cur_s][wr_way] <= din_valid;
        if (w_dirty_en) e_dty[cur_s][wr_way] <= din_dirty;
        if (w_lru_en)   e_lru[cur_s]         <= din_lru;
    end

    // Reference cache and counters, updated per access from the behavioural rules
    int r_tag [NS][2];
    bit r_vld [NS][2];
    bit r_dty [NS][2];
    bit r_lru [NS];
    int r_hits = 0, r_miss = 0, r_wb = 0;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input int s);
        chk("hit_count", 32'(hit_count), r_hits);
        chk("miss_count", 32'(miss_count), r_miss);
        chk("wb_count", 32'(wb_count), r_wb);
        for (int k = 0; k < 2; k++) begin
            chk("way_tag", e_tag[s][k], r_tag[s][k]);
            chk("way_valid", 32'(e_vld[s][k]), 32'(r_vld[s][k]));
            chk("way_dirty", 32'(e_dty[s][k]), 32'(r_dty[s][k]));
        end
        chk("set_lru", 32'(e_lru[s]), 32'(r_lru[s]));
    endtask

    function automatic logic [11:0] all_outs();
        return {mem_resp, pmem_read, pmem_write, pmem_addr_sel, w_data_en, w_tag_en,
                w_valid_en, w_dirty_en, w_lru_en, din_valid, din_dirty, din_lru};
    endfunction

    // One CPU access. pmem responds after random delays. Traffic and latency are checked.
    task automatic access(input bit wr, input bit both, input int s, input int t);
        int w, dw, df, wcnt, nrd, nwr, cyc, lat;
        bit hit, wb, got, wx;
        hit = 0;
        w   = r_lru[s];
        for (int k = 0; k < 2; k++)
            if (r_vld[s][k] && r_tag[s][k] == t) begin
                hit = 1;
                w   = k;
            end
        wb  = !hit && r_vld[s][w] && r_dty[s][w];
        wx  = wr | both;
        dw  = $urandom_range(3, 0);
        df  = $urandom_range(4, 0);
        lat = hit ? 0 : ((wb ? dw + 1 : 0) + df + 2);
        @(negedge clk);
        cur_s     = s;
        cur_t     = t;
        mem_write = wr | both;
        mem_read  = !wr | both;
        cyc = 0; wcnt = 0; nrd = 0; nwr = 0; got = 0;
        while (!got && cyc < 64) begin
            pmem_resp = 1'b0;
            #1;
            chk("pmem_exclusive", 32'(pmem_read & pmem_write), 0);
            if (pmem_write) begin
                nwr++;
                chk("wb_addr_sel", 32'(pmem_addr_sel), 1);
                if (wcnt == dw) begin pmem_resp = 1'b1; wcnt = 0; end
                else wcnt++;
            end else if (pmem_read) begin
                nrd++;
                chk("fill_addr_sel", 32'(pmem_addr_sel), 0);
                if (wcnt == df) begin pmem_resp = 1'b1; wcnt = 0; end
                else wcnt++;
            end
            #1;
            if (mem_resp) begin
                got = 1;
                chk("resp_lru_en", 32'(w_lru_en), 1);
                chk("resp_din_lru", 32'(din_lru), 32'(w == 0));
                chk("resp_data_en", 32'(w_data_en), 32'(wx));
                chk("resp_dirty_en", 32'(w_dirty_en), 32'(wx));
                chk("resp_din_dirty", 32'(din_dirty), 32'(wx));
                chk("resp_tag_en", 32'(w_tag_en), 0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("resp_seen", 32'(got), 1);
        chk("latency", cyc, lat);
        chk("wb_cycles", nwr, wb ? dw + 1 : 0);
        chk("fill_cycles", nrd, hit ? 0 : df + 1);
        if (!hit) begin
            r_miss = sat(r_miss);
            if (wb) r_wb = sat(r_wb);
            r_tag[s][w] = t;
            r_vld[s][w] = 1;
            r_dty[s][w] = 0;
        end
        r_hits   = sat(r_hits);
        r_lru[s] = (w == 0);
        if (wx) r_dty[s][w] = 1;
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        #1;
        check_state(s);
    endtask

    // Miss whose request is dropped once the pmem transfer has started
    task automatic withdraw(input int s, input int t);
        int  w, nresp;
        bit  wb;
        w     = r_lru[s];
        wb    = r_vld[s][w] && r_dty[s][w];
        nresp = 0;
        @(negedge clk);
        cur_s    = s;
        cur_t    = t;
        mem_read = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) mem_read = 1'b0;
            pmem_resp = 1'b0;
            #1;
            if (pmem_read | pmem_write) pmem_resp = 1'b1;
            #1;
            if (mem_resp) nresp++;
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        chk("withdraw_no_resp", nresp, 0);
        r_miss = sat(r_miss);
        if (wb) r_wb = sat(r_wb);
        r_tag[s][w] = t;
        r_vld[s][w] = 1;
        r_dty[s][w] = 0;
        #1;
        check_state(s);
        chk("withdraw_idle", 32'(all_outs()), 0);
    endtask

    // Reset asserted while FILL waits on pmem: transfer abandoned, arrays untouched
    task automatic reset_mid_fill(input int s, input int t);
        bit reached;
        reached = 0;
        @(negedge clk);
        cur_s    = s;
        cur_t    = t;
        mem_read = 1'b1;
        for (int c = 0; c < 12 && !reached; c++) begin
            pmem_resp = 1'b0;
            #1;
            if (pmem_read) reached = 1;
            else begin
                if (pmem_write) pmem_resp = 1'b1;
                @(negedge clk);
            end
        end
        chk("rst_reach_fill", 32'(reached), 1);
        rst_n     = 1'b0;
        pmem_resp = 1'b1;
        #1;
        chk("rst_pmem_read_drop", 32'(pmem_read), 0);
        chk("rst_outputs", 32'(all_outs()), 0);
        @(negedge clk);
        @(negedge clk);
        mem_read  = 1'b0;
        pmem_resp = 1'b0;
        rst_n     = 1'b1;
        r_hits = 0; r_miss = 0; r_wb = 0;
        #1;
        check_state(s);
        @(negedge clk);
        #1;
        chk("rst_idle_after", 32'(all_outs()), 0);
    endtask

    initial begin
        // Reset state, with a request and a stray pmem_resp present
        mem_read  = 1'b1;
        pmem_resp = 1'b1;
        #12;
        chk("reset_outputs", 32'(all_outs()), 0);
        chk("reset_hit_count", 32'(hit_count), 0);
        chk("reset_miss_count", 32'(miss_count), 0);
        chk("reset_wb_count", 32'(wb_count), 0);
        @(negedge clk);
        mem_read  = 1'b0;
        pmem_resp = 1'b0;
        rst_n     = 1'b1;

        // A stray pmem_resp in IDLE is ignored
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        chk("stray_outputs", 32'(all_outs()), 0);
        @(negedge clk);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check_state(0);

        // Cold read, then a write hit to the same line
        access(1'b0, 1'b0, 0, 1);
        access(1'b1, 1'b0, 0, 1);
        // Read and write together are serviced as a write
        access(1'b0, 1'b1, 1, 2);

        // Random traffic: few sets and tags keep evictions of dirty lines frequent
        for (int i = 0; i < 250; i++)
            access($urandom_range(1, 0), ($urandom_range(7, 0) == 0),
                   $urandom_range(NS - 1, 0), $urandom_range(3, 0));

        withdraw(0, 9);
        reset_mid_fill(1, 10);

        // Saturation: a held hit request completes once per cycle
        access(1'b0, 1'b0, 2, 1);
        @(negedge clk);
        cur_s    = 2;
        cur_t    = 1;
        mem_read = 1'b1;
        repeat ((1 << CW) + 3) @(negedge clk);
        #1;
        chk("hit_saturate", 32'(hit_count), MAXC);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        mem_read  = 1'b0;
        #1;
        chk("clr_hit_count", 32'(hit_count), 0);
        chk("clr_miss_count", 32'(miss_count), 0);
        chk("clr_wb_count", 32'(wb_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
